// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Runs one 4-point FFT frame end to end. It collects four samples from an
//   input stream into the sample memory and reads them back as two pairs. It
//   loads the FFT core operands, pulses start and waits for done under a
//   watchdog. It then streams the four captured bins out.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   i_abort                   synchronous abort: drop the frame, back to S_FILL
//   i_in_valid/o_in_ready     sample stream handshake, data on i_in_data
//   o_mem_*                   sample memory write port and dual read ports
//   i_mem_data_out_a/b        memory read data (registered, 1-cycle latency)
//   o_fft_sample0..3          registered operands to the FFT core
//   o_fft_start/i_fft_done    one-cycle start pulse / completion (level or pulse)
//   i_fft_freq0..3            core results, captured on done
//   o_out_valid/i_out_ready   bin stream handshake, o_out_data/o_out_index
//   o_busy                    high in every state except S_FILL
//   o_timeout_err             sticky watchdog flag, cleared by abort or reset
//   o_dbg_state               current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. While valid is high and ready is low, the data and the index stay stable.
// The sender does not wait for ready before it raises valid.
module fft_frame_sequencer #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_abort,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_mem_en,
  output logic              o_mem_write_en,
  output logic              o_mem_read_en,
  output logic [1:0]        o_mem_addr_w,
  output logic [DATA_W-1:0] o_mem_data_in,
  output logic [1:0]        o_mem_addr_a,
  output logic [1:0]        o_mem_addr_b,
  input  logic [DATA_W-1:0] i_mem_data_out_a,
  input  logic [DATA_W-1:0] i_mem_data_out_b,
  output logic [DATA_W-1:0] o_fft_sample0,
  output logic [DATA_W-1:0] o_fft_sample1,
  output logic [DATA_W-1:0] o_fft_sample2,
  output logic [DATA_W-1:0] o_fft_sample3,
  output logic              o_fft_start,
  input  logic              i_fft_done,
  input  logic [DATA_W-1:0] i_fft_freq0,
  input  logic [DATA_W-1:0] i_fft_freq1,
  input  logic [DATA_W-1:0] i_fft_freq2,
  input  logic [DATA_W-1:0] i_fft_freq3,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [1:0]        o_out_index,
  output logic              o_busy,
  output logic              o_timeout_err,
  output logic [2:0]        o_dbg_state
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_RD01  = 3'd1,
    S_RD23  = 3'd2,
    S_LAT   = 3'd3,
    S_START = 3'd4,
    S_WAIT  = 3'd5,
    S_DRAIN = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t            r_state;
  logic [1:0]        r_fill_cnt;
  logic [1:0]        r_out_idx;
  logic [WD_W-1:0]   r_wdog;
  logic              r_timeout_err;
  logic [DATA_W-1:0] r_sample [4];
  logic [DATA_W-1:0] r_result [4];

  logic              w_accept;
  logic [WD_W-1:0]   w_wdog_inc;

  assign o_in_ready = (r_state == S_FILL) && !i_abort;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_wdog_inc = r_wdog + 1'b1;

  // The memory port is driven straight from the state. Read data returns one
  // cycle later, so the pair addressed in S_RD01 is captured in S_RD23, and the
  // pair addressed in S_RD23 is captured in S_LAT.
  always_comb begin
    o_mem_write_en = 1'b0;
    o_mem_read_en  = 1'b0;
    o_mem_addr_w   = 2'd0;
    o_mem_data_in  = '0;
    o_mem_addr_a   = 2'd0;
    o_mem_addr_b   = 2'd0;
    if (w_accept) begin
      o_mem_write_en = 1'b1;
      o_mem_addr_w   = r_fill_cnt;
      o_mem_data_in  = i_in_data;
    end
    if (r_state == S_RD01) begin
      o_mem_read_en = 1'b1;
      o_mem_addr_a  = 2'd0;
      o_mem_addr_b  = 2'd1;
    end else if (r_state == S_RD23) begin
      o_mem_read_en = 1'b1;
      o_mem_addr_a  = 2'd2;
      o_mem_addr_b  = 2'd3;
    end
    o_mem_en = o_mem_write_en || o_mem_read_en;
  end

  assign o_fft_start   = (r_state == S_START) && !i_abort;
  assign o_out_valid   = (r_state == S_DRAIN) && !i_abort;
  assign o_out_data    = r_result[r_out_idx];
  assign o_out_index   = r_out_idx;
  assign o_busy        = (r_state != S_FILL);
  assign o_timeout_err = r_timeout_err;
  assign o_dbg_state   = r_state;
  assign o_fft_sample0 = r_sample[0];
  assign o_fft_sample1 = r_sample[1];
  assign o_fft_sample2 = r_sample[2];
  assign o_fft_sample3 = r_sample[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FILL;
      r_fill_cnt    <= 2'd0;
      r_out_idx     <= 2'd0;
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_sample[i] <= '0;
        r_result[i] <= '0;
      end
    end else if (i_abort) begin
      // Abort drops the frame but keeps the operand and result registers.
      r_state       <= S_FILL;
      r_fill_cnt    <= 2'd0;
      r_out_idx     <= 2'd0;
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (r_fill_cnt == 2'd3) begin
              r_fill_cnt <= 2'd0;
              r_state    <= S_RD01;
            end else begin
              r_fill_cnt <= r_fill_cnt + 2'd1;
            end
          end
        end
        S_RD01: r_state <= S_RD23;
        S_RD23: begin
          r_sample[0] <= i_mem_data_out_a;
          r_sample[1] <= i_mem_data_out_b;
          r_state     <= S_LAT;
        end
        S_LAT: begin
          r_sample[2] <= i_mem_data_out_a;
          r_sample[3] <= i_mem_data_out_b;
          r_state     <= S_START;
        end
        S_START: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Done wins over watchdog expiry in the same cycle.
          if (i_fft_done) begin
            r_result[0] <= i_fft_freq0;
            r_result[1] <= i_fft_freq1;
            r_result[2] <= i_fft_freq2;
            r_result[3] <= i_fft_freq3;
            r_out_idx   <= 2'd0;
            r_state     <= S_DRAIN;
          end else if (w_wdog_inc == WD_LAST) begin
            r_wdog        <= w_wdog_inc;
            r_timeout_err <= 1'b1;
            r_state       <= S_ERR;
          end else begin
            r_wdog <= w_wdog_inc;
          end
        end
        S_DRAIN: begin
          if (i_out_ready) begin
            if (r_out_idx == 2'd3) begin
              r_out_idx  <= 2'd0;
              r_fill_cnt <= 2'd0;
              r_state    <= S_FILL;
            end else begin
              r_out_idx <= r_out_idx + 2'd1;
            end
          end
        end
        S_ERR:   r_state <= S_ERR;
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer. It includes a behavioural sample
// memory (registered reads) and a small FFT core model. The core raises done a
// programmable number of cycles after start, and shows its results only while
// done is high.
module tb_fft_frame_sequencer;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          mem_en, mem_we, mem_re;
  logic [1:0]    mem_addr_w, mem_addr_a, mem_addr_b;
  logic [W-1:0]  mem_data_in, mem_out_a, mem_out_b;
  logic [W-1:0]  s0, s1, s2, s3;
  logic          fft_start;
  logic          core_done;
  logic [W-1:0]  f0, f1, f2, f3;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    out_index;
  logic          busy, timeout_err;
  logic [2:0]    dbg_state;

  fft_frame_sequencer #(.DATA_W(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .i_abort(abort),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_mem_en(mem_en), .o_mem_write_en(mem_we), .o_mem_read_en(mem_re),
    .o_mem_addr_w(mem_addr_w), .o_mem_data_in(mem_data_in),
    .o_mem_addr_a(mem_addr_a), .o_mem_addr_b(mem_addr_b),
    .i_mem_data_out_a(mem_out_a), .i_mem_data_out_b(mem_out_b),
    .o_fft_sample0(s0), .o_fft_sample1(s1), .o_fft_sample2(s2), .o_fft_sample3(s3),
    .o_fft_start(fft_start), .i_fft_done(core_done),
    .i_fft_freq0(f0), .i_fft_freq1(f1), .i_fft_freq2(f2), .i_fft_freq3(f3),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_index(out_index),
    .o_busy(busy), .o_timeout_err(timeout_err), .o_dbg_state(dbg_state)
  );

  // ---------------- sample memory model ----------------
  logic [W-1:0] mem [4];
  logic [W-1:0] rd_a = '0, rd_b = '0;
  assign mem_out_a = rd_a;
  assign mem_out_b = rd_b;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr_w] <= mem_data_in;
    if (mem_en && mem_re) begin
      rd_a <= mem[mem_addr_a];
      rd_b <= mem[mem_addr_b];
    end
  end

  // ---------------- FFT core model ----------------
  int           core_delay = 5;  // 0 = never completes
  int           core_cnt = 0;
  logic [W-1:0] res [4];
  assign f0 = core_done ? res[0] : 16'hBAD0;
  assign f1 = core_done ? res[1] : 16'hBAD1;
  assign f2 = core_done ? res[2] : 16'hBAD2;
  assign f3 = core_done ? res[3] : 16'hBAD3;
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (rst) begin
      core_cnt <= 0;
    end else if (fft_start && core_delay != 0) begin
      core_cnt <= 1;
    end else if (core_cnt != 0) begin
      if (core_cnt == core_delay) begin
        core_done <= 1'b1;
        core_cnt  <= 0;
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Sends four samples back to back. It checks each write and the start pulse
  // latency, then returns at the negedge of the S_START cycle.
  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W-1:0] smp [4];
    smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = smp[k];
      #1;
      check("in_ready", in_ready, 1'b1);
      check("wr_en", mem_we, 1'b1);
      check("wr_addr", mem_addr_w, k[1:0]);
      check("wr_data", mem_data_in, smp[k]);
      step();
    end
    in_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      if (n == 3) check("start_early", fft_start, 1'b0);
      if (n == 4) begin
        check("start_T+4", fft_start, 1'b1);
        check("sample0", s0, a);
        check("sample1", s1, b);
        check("sample2", s2, c);
        check("sample3", s3, d);
      end else begin
        step();
      end
    end
  endtask

  // Waits for the bin stream and drains it against the expected queue.
  task automatic drain(input bit toggle, input logic [W-1:0] e0, input logic [W-1:0] e1,
                       input logic [W-1:0] e2, input logic [W-1:0] e3);
    int idx = 0;
    int budget = 0;
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2); exp_q.push_back(e3);
    out_ready = 1'b0;
    while (exp_q.size() > 0 && budget < 200) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      #1;
      if (out_valid) begin
        check("out_index", out_index, idx[1:0]);
        check("out_data", out_data, exp_q[0]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          idx++;
        end
      end
      step();
      budget++;
    end
    out_ready = 1'b0;
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    #1;
    check("post_out_valid", out_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    check("post_busy", busy, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    res[0] = '0; res[1] = '0; res[2] = '0; res[3] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_start", fft_start, 1'b0);
    check("rst_err", timeout_err, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    check("rst_sample0", s0, 16'h0);

    // basic frame, free-flowing output
    core_delay = 5;
    res[0] = 16'd10; res[1] = 16'hFFFE; res[2] = 16'hFFFE; res[3] = 16'hFFFE;
    step();
    send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    drain(1'b0, 16'd10, 16'hFFFE, 16'hFFFE, 16'hFFFE);

    // second frame, out_ready toggling every cycle
    res[0] = 16'h0011; res[1] = 16'h0022; res[2] = 16'h0033; res[3] = 16'h0044;
    send_frame(16'h0005, 16'h0006, 16'h0007, 16'h0008);
    drain(1'b1, 16'h0011, 16'h0022, 16'h0033, 16'h0044);

    // watchdog: core never completes, TIMEOUT = 8
    core_delay = 0;
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    repeat (7) step();
    check("err_before", timeout_err, 1'b0);
    step();
    check("err_at_8", timeout_err, 1'b1);
    check("err_state", dbg_state, 3'd7);
    repeat (3) step();
    check("err_sticky", timeout_err, 1'b1);
    check("err_busy", busy, 1'b1);
    abort = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1'b0);
    step();
    abort = 1'b0;
    #1;
    check("abort_err_clr", timeout_err, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready2", in_ready, 1'b1);

    // abort arriving with the 3rd sample
    core_delay = 5;
    in_valid = 1'b1; in_data = 16'h000A; #1;
    check("ab_wr0", mem_addr_w, 2'd0);
    step();
    in_data = 16'h000B; #1;
    check("ab_wr1", mem_addr_w, 2'd1);
    step();
    in_data = 16'h000C; abort = 1'b1; #1;
    check("ab_wr_suppr", mem_we, 1'b0);
    check("ab_in_ready", in_ready, 1'b0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    res[0] = 16'h0100; res[1] = 16'h0200; res[2] = 16'h0300; res[3] = 16'h0400;
    send_frame(16'h0021, 16'h0022, 16'h0023, 16'h0024);
    drain(1'b0, 16'h0100, 16'h0200, 16'h0300, 16'h0400);

    // reset in the middle of filling
    in_valid = 1'b1; in_data = 16'h0055; step();
    in_data = 16'h0066; step();
    in_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0; #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sample0", s0, 16'h0);

    // done arrives on the watchdog expiry cycle
    core_delay = 6;
    res[0] = 16'h7FFF; res[1] = 16'h8000; res[2] = 16'h0001; res[3] = 16'hFFFF;
    send_frame(16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4);
    repeat (7) step();
    check("exp_done_seen", core_done, 1'b1);
    step();
    check("exp_no_err", timeout_err, 1'b0);
    check("exp_drain", out_valid, 1'b1);
    drain(1'b0, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
